// File: rtl/mem_arbiter_if.sv
// Memory-side request/acknowledge bus shared by instruction fetch and data access.
// The arbiter is the master; the memory or SPI-SRAM bridge is the slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the core's fetch and data ports.
// Each core step runs settle -> data access -> fetch -> one unstalled cycle.
module mem_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic        mem_write_m,
    input  logic        mem_read_m,
    output logic        stall,
    output logic [31:0] inst_f,
    output logic [31:0] read_data_m,
    output logic        err,
    mem_arbiter_if.master mem
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int SET_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_SETTLE, S_DATA, S_FETCH, S_GO} state_t;

    state_t            state_reg;
    logic [SET_W-1:0]  settle_cnt_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              req_reg;
    logic              we_reg;
    logic              stall_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       inst_reg;
    logic [31:0]       rdata_reg;

    logic ack_seen;
    logic timeout_hit;
    logic done;

    // An ack arriving in the same cycle as the timeout limit still counts as a real completion.
    assign ack_seen    = req_reg & mem.ack;
    assign timeout_hit = (TIMEOUT != 0) && req_reg && !mem.ack
                         && (wait_cnt_reg == CNT_W'(TO_LAST));
    assign done        = ack_seen | timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_SETTLE;
            settle_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            stall_reg      <= 1'b1;
            err_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            inst_reg       <= NOP;
            rdata_reg      <= '0;
        end else begin
            if (req_reg && !done && wait_cnt_reg != CNT_MAX)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (timeout_hit)
                err_reg <= 1'b1;

            case (state_reg)
                S_SETTLE: begin
                    if (SETTLE == 0 || settle_cnt_reg == SET_W'(SET_LAST)) begin
                        settle_cnt_reg <= '0;
                        state_reg      <= S_DATA;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    // req low: sample the core and issue; req high: wait for completion.
                    if (!req_reg) begin
                        if (mem_write_m) begin
                            req_reg      <= 1'b1;
                            we_reg       <= 1'b1;
                            addr_reg     <= alu_result_m[ADDR_W-1:0];
                            wdata_reg    <= write_data_m;
                            wait_cnt_reg <= '0;
                        end else if (mem_read_m) begin
                            req_reg      <= 1'b1;
                            we_reg       <= 1'b0;
                            addr_reg     <= alu_result_m[ADDR_W-1:0];
                            wait_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end else if (done) begin
                        req_reg <= 1'b0;
                        if (!we_reg)
                            rdata_reg <= ack_seen ? mem.rdata : 32'h0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!req_reg) begin
                        req_reg      <= 1'b1;
                        we_reg       <= 1'b0;
                        addr_reg     <= pc_f[ADDR_W-1:0];
                        wait_cnt_reg <= '0;
                    end else if (done) begin
                        req_reg   <= 1'b0;
                        inst_reg  <= ack_seen ? mem.rdata : NOP;
                        stall_reg <= 1'b0;
                        state_reg <= S_GO;
                    end
                end
                S_GO: begin
                    stall_reg <= 1'b1;
                    state_reg <= S_SETTLE;
                end
                default: state_reg <= S_SETTLE;
            endcase
        end
    end

    assign stall       = stall_reg;
    assign inst_f      = inst_reg;
    assign read_data_m = rdata_reg;
    assign err         = err_reg;
    assign mem.req     = req_reg;
    assign mem.we      = we_reg;
    assign mem.addr    = addr_reg;
    assign mem.wdata   = wdata_reg;

    // Address bits above ADDR_W are intentionally dropped.
    generate
        if (ADDR_W < 32) begin : g_drop_hi
            logic unused_hi;
            assign unused_hi = ^{pc_f[31:ADDR_W], alu_result_m[31:ADDR_W]};
        end
    endgenerate
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised step-level check of mem_arbiter against a memory responder and a
// transaction/latency model derived from the arbiter's step rules.
module tb_mem_arbiter;
    localparam int ADDR_W  = 24;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 4;
    localparam int NEVER   = 255;
    localparam int NSTEPS  = 40;

    typedef struct packed {
        logic [23:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f, alu_result_m, write_data_m;
    logic        mem_write_m, mem_read_m;
    logic        stall, err;
    logic [31:0] inst_f, read_data_m;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) mif ();

    mem_arbiter #(.ADDR_W(ADDR_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_f         (pc_f),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .mem_write_m  (mem_write_m),
        .mem_read_m   (mem_read_m),
        .stall        (stall),
        .inst_f       (inst_f),
        .read_data_m  (read_data_m),
        .err          (err),
        .mem          (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Memory environment state
    logic [31:0] mem_store [logic [23:0]];
    int   wq [$];
    txn_t log_q [$];
    int   stab_err = 0;
    bit   spur_en  = 1'b0;

    // Reference model state
    logic [31:0] ref_store [logic [23:0]];
    txn_t        exp_q [$];
    logic [31:0] exp_inst = 32'h13;
    logic [31:0] exp_read = 32'h0;
    logic        exp_err  = 1'b0;
    int          exp_len  = 0;

    function automatic logic [31:0] mem_default(input logic [23:0] a);
        return {8'h5A, a} ^ ({8'h0, a} << 7);
    endfunction

    function automatic logic [31:0] ref_val(input logic [23:0] a);
        if (ref_store.exists(a)) return ref_store[a];
        return mem_default(a);
    endfunction

    function automatic int req_cycles(input int w);
        return (w == NEVER) ? TIMEOUT : w + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bail(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT event missing within cycle budget", tag);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Memory responder: acks each request after its queued number of wait cycles.
    initial begin
        bit          in_txn;
        int          cur_wait, wcnt;
        txn_t        cur;
        in_txn = 1'b0; cur_wait = 0; wcnt = 0; cur = '0;
        mif.ack = 1'b0;
        mif.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mif.ack = 1'b0;
            if (mif.req === 1'b1) begin
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    cur.addr   = mif.addr;
                    cur.we     = mif.we;
                    cur.wdata  = mif.wdata;
                    cur_wait   = (wq.size() > 0) ? wq.pop_front() : 0;
                    wcnt       = 0;
                    log_q.push_back(cur);
                end else if (mif.addr !== cur.addr || mif.we !== cur.we || mif.wdata !== cur.wdata) begin
                    stab_err++;
                end
                if (wcnt == cur_wait) begin
                    mif.ack = 1'b1;
                    if (cur.we) begin
                        mem_store[cur.addr] = cur.wdata;
                        mif.rdata = $urandom;
                    end else begin
                        mif.rdata = mem_store.exists(cur.addr) ? mem_store[cur.addr] : mem_default(cur.addr);
                    end
                    in_txn = 1'b0;
                end else begin
                    wcnt++;
                end
            end else begin
                in_txn = 1'b0;
                if (spur_en && $urandom_range(0, 2) == 0) begin
                    mif.ack   = 1'b1;
                    mif.rdata = $urandom;
                end
            end
        end
    end

    // op: 0 none, 1 load, 2 store, 3 load+store (store wins)
    task automatic plan_step(input int op, input logic [31:0] alu, input logic [31:0] wdat,
                             input logic [31:0] pc, input int wd, input int wf);
        txn_t t;
        bit   acc, is_wr;
        alu_result_m = alu;
        write_data_m = wdat;
        pc_f         = pc;
        mem_write_m  = (op == 2 || op == 3);
        mem_read_m   = (op == 1 || op == 3);
        is_wr = (op == 2 || op == 3);
        acc   = (op != 0);
        exp_q.delete();
        log_q.delete();
        if (acc) begin
            t.addr = alu[23:0]; t.we = is_wr; t.wdata = is_wr ? wdat : 32'h0;
            exp_q.push_back(t);
            wq.push_back(wd);
            if (wd == NEVER) exp_err = 1'b1;
            else if (is_wr) ref_store[alu[23:0]] = wdat;
            if (!is_wr) exp_read = (wd == NEVER) ? 32'h0 : ref_val(alu[23:0]);
        end
        t.addr = pc[23:0]; t.we = 1'b0; t.wdata = 32'h0;
        exp_q.push_back(t);
        wq.push_back(wf);
        exp_inst = (wf == NEVER) ? 32'h13 : ref_val(pc[23:0]);
        if (wf == NEVER) exp_err = 1'b1;
        // settle, one sampling/issue cycle, data req cycles, one req-low cycle
        // to issue the fetch, fetch req cycles, then the single unstalled cycle
        exp_len = SETTLE + 1 + (acc ? req_cycles(wd) : 0) + 1 + req_cycles(wf) + 1;
    endtask

    task automatic run_step(input bit check_len);
        int n;
        bit got;
        n = 0; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && check_len) chk("stall_one_cycle", {31'h0, stall}, 32'h1);
            if (stall === 1'b0) got = 1'b1;
        end
        if (!got) bail("step_go");
        if (check_len) chk("step_len", n, exp_len);
        chk("inst_f", inst_f, exp_inst);
        chk("read_data_m", read_data_m, exp_read);
        chk("err", {31'h0, err}, {31'h0, exp_err});
        chk("bus_stable", stab_err, 0);
        chk("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("txn_addr", {8'h0, log_q[i].addr}, {8'h0, exp_q[i].addr});
            chk("txn_we", {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
            if (exp_q[i].we) chk("txn_wdata", log_q[i].wdata, exp_q[i].wdata);
        end
    endtask

    initial begin
        int n;
        int op, wd, wf;
        logic [31:0] tmp, alu, pc, wdat;

        reset = 1'b0;
        pc_f = 0; alu_result_m = 0; write_data_m = 0; mem_write_m = 0; mem_read_m = 0;
        mem_store[24'h100] = 32'hDEAD_BEEF; ref_store[24'h100] = 32'hDEAD_BEEF;
        mem_store[24'h040] = 32'h0050_0093; ref_store[24'h040] = 32'h0050_0093;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h1);
        chk("rst_req", {31'h0, mif.req}, 32'h0);
        chk("rst_inst", inst_f, 32'h13);
        chk("rst_read", read_data_m, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // Load at 0x100 acked after 3 waits, then fetch
        plan_step(1, 32'h100, 32'h0, 32'h200, 3, 0);
        @(negedge clk) reset = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (mif.req !== 1'b1 && n < 50);
        chk("first_req_delay", n, SETTLE + 1);
        run_step(1'b0);

        for (int s = 0; s < NSTEPS; s++) begin
            spur_en = 1'b0;
            if (s == 0) begin
                op = 0; alu = 0; wdat = 0; pc = 32'h40; wd = 0; wf = 0;
            end else if (s == 1) begin
                op = 3; alu = 32'd100; wdat = 32'd25; pc = 32'h44; wd = 2; wf = 1;
            end else if (s == 2) begin
                op = 0; alu = 0; wdat = 0; pc = 32'h48; wd = 0; wf = NEVER;
            end else begin
                spur_en = ($urandom_range(0, 1) == 1);
                op   = $urandom_range(0, 3);
                tmp  = $urandom;
                alu  = (tmp & 32'hFF00_0000) | (32'($urandom_range(0, 15)) << 2);
                tmp  = $urandom;
                pc   = (tmp & 32'hFF00_0000) | (32'($urandom_range(0, 15)) << 2);
                wdat = $urandom;
                wd   = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
                wf   = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
            end
            plan_step(op, alu, wdat, pc, wd, wf);
            run_step(1'b1);
        end

        // Reset while a load request is outstanding
        spur_en = 1'b0;
        plan_step(1, 32'h300, 32'h0, 32'h50, NEVER, 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (mif.req !== 1'b1 && n < 50);
        if (mif.req !== 1'b1) bail("req_before_reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_req", {31'h0, mif.req}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h1);
        chk("midrst_inst", inst_f, 32'h13);
        chk("midrst_err", {31'h0, err}, 32'h0);
        chk("midrst_read", read_data_m, 32'h0);
        exp_inst = 32'h13; exp_read = 32'h0; exp_err = 1'b0;
        wq.delete();
        repeat (2) @(posedge clk);
        #1;
        stab_err = 0;
        plan_step(1, 32'h104, 32'h0, 32'h54, 1, 2);
        @(negedge clk) reset = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (mif.req !== 1'b1 && n < 50);
        chk("req_after_release", n, SETTLE + 1);
        run_step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
